// File: rtl/riscie_pkg.sv
// Shared encodings for the riscie MEM stage: func3 access codes, control-bit
// positions and FSM states.
package riscie_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MC_BRANCH   = 2;
  localparam int MC_READ     = 1;
  localparam int MC_WRITE    = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int WB_REGWRITE = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    return ((func3[1:0] == SZ_HALF) && addr_lo[0]) ||
           ((func3[1:0] == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port: one outstanding access, request held until ack.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              dmemReq;
  logic              dmemWe;
  logic [ADDR_W-1:0] dmemAddr;
  logic [31:0]       dmemWdata;
  logic [3:0]        dmemBe;
  logic              dmemAck;
  logic [31:0]       dmemRdata;

  modport master (
    output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    input  dmemAck, dmemRdata
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    output dmemAck, dmemRdata
  );
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane steering: store replication/byte enables and
// load extract with sign/zero extension.
module mem_align
  import riscie_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] raw_rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  store_be,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    lane_wdata = store_data;
    store_be   = 4'b1111;
    case (func3[1:0])
      SZ_BYTE: begin
        lane_wdata = {4{store_data[7:0]}};
        store_be   = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        lane_wdata = {2{store_data[15:0]}};
        store_be   = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = raw_rdata[7:0];
    case (addr_lo)
      2'd1:    ld_byte = raw_rdata[15:8];
      2'd2:    ld_byte = raw_rdata[23:16];
      2'd3:    ld_byte = raw_rdata[31:24];
      default: ;
    endcase
    ld_half   = addr_lo[1] ? raw_rdata[31:16] : raw_rdata[15:0];
    load_data = raw_rdata;
    case (func3)
      F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  load_data = {24'h0, ld_byte};
      F3_LHU:  load_data = {16'h0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// riscie MEM stage: issues loads/stores on the req/ack port, stalls the
// pipeline while an access is outstanding and registers MEM/WB.
module mem_stage
  import riscie_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exmemAlu,
  input  logic [31:0] exmemReg2,
  input  logic [4:0]  exmemRd,
  input  logic        exmemZero,
  input  logic [2:0]  exmemFunc3,
  input  logic [2:0]  exmemMemCtrl,
  input  logic [1:0]  exmemWbCtrl,
  mem_stage_if.master dmem,
  output logic        memStall,
  output logic        pcSrc,
  output logic [4:0]  memwbRd,
  output logic [1:0]  memwbWbCtrl,
  output logic [31:0] memwbAlu,
  output logic [31:0] memwbReadData,
  output logic        memFault
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             memop, is_load, misaligned, acked, timed_out;
  logic [31:0]      lane_wdata, load_data;
  logic [3:0]       store_be;

  mem_align u_align (
    .func3      (exmemFunc3),
    .addr_lo    (exmemAlu[1:0]),
    .store_data (exmemReg2),
    .raw_rdata  (dmem.dmemRdata),
    .lane_wdata (lane_wdata),
    .store_be   (store_be),
    .load_data  (load_data)
  );

  assign memop      = exmemMemCtrl[MC_READ] | exmemMemCtrl[MC_WRITE];
  assign is_load    = exmemMemCtrl[MC_READ];
  assign misaligned = memop && is_misaligned(exmemFunc3, exmemAlu[1:0]);

  // Request is killed while reset is held so an abandoned access never leaks out.
  assign dmem.dmemReq   = !rst && ((state == ST_IDLE && memop && !misaligned) || state == ST_WAIT);
  assign dmem.dmemWe    = memop && !is_load;
  assign dmem.dmemAddr  = {exmemAlu[ADDR_W-1:2], 2'b00};
  assign dmem.dmemWdata = lane_wdata;
  assign dmem.dmemBe    = is_load ? 4'b1111 : store_be;

  assign acked     = dmem.dmemReq && dmem.dmemAck;
  assign timed_out = (state == ST_WAIT) && !dmem.dmemAck && (wait_cnt == CNT_LAST);
  assign memStall  = dmem.dmemReq && !dmem.dmemAck && !timed_out;
  assign pcSrc     = exmemMemCtrl[MC_BRANCH] & exmemZero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      memFault      <= 1'b0;
      memwbRd       <= '0;
      memwbWbCtrl   <= 2'b00;
      memwbAlu      <= '0;
      memwbReadData <= '0;
    end else begin
      memwbRd     <= exmemRd;
      memwbAlu    <= exmemAlu;
      // Anything other than a finished access or a plain ALU op is a bubble.
      memwbWbCtrl <= (!memop || acked) ? exmemWbCtrl : 2'b00;
      if (acked)
        memwbReadData <= load_data;
      if ((state == ST_IDLE && misaligned) || timed_out)
        memFault <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (dmem.dmemReq && !dmem.dmemAck) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (dmem.dmemAck || timed_out)
            state <= ST_IDLE;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: drives EX/MEM ops and a scripted memory ack.
module tb_mem_stage;
  import riscie_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] exmemAlu, exmemReg2;
  logic [4:0]  exmemRd;
  logic        exmemZero;
  logic [2:0]  exmemFunc3, exmemMemCtrl;
  logic [1:0]  exmemWbCtrl;
  logic        memStall, pcSrc, memFault;
  logic [4:0]  memwbRd;
  logic [1:0]  memwbWbCtrl;
  logic [31:0] memwbAlu, memwbReadData;

  mem_stage_if #(.ADDR_W(32)) dmem ();

  mem_stage #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .exmemAlu      (exmemAlu),
    .exmemReg2     (exmemReg2),
    .exmemRd       (exmemRd),
    .exmemZero     (exmemZero),
    .exmemFunc3    (exmemFunc3),
    .exmemMemCtrl  (exmemMemCtrl),
    .exmemWbCtrl   (exmemWbCtrl),
    .dmem          (dmem),
    .memStall      (memStall),
    .pcSrc         (pcSrc),
    .memwbRd       (memwbRd),
    .memwbWbCtrl   (memwbWbCtrl),
    .memwbAlu      (memwbAlu),
    .memwbReadData (memwbReadData),
    .memFault      (memFault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [31:0] alu;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          op_n    = 0;
  logic        exp_fault = 1'b0;
  logic        rdata_known = 1'b0;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a));
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LBU:  return {24'h0, b};
      F3_LHU:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic drive_nop();
    exmemAlu = '0; exmemReg2 = '0; exmemRd = '0; exmemZero = 1'b0;
    exmemFunc3 = '0; exmemMemCtrl = '0; exmemWbCtrl = '0;
    dmem.dmemAck = 1'b0; dmem.dmemRdata = '0;
  endtask

  // Called just after a posedge; returns just after the posedge that retires the op.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [2:0] mc,
                        input logic [1:0] wb, input logic [31:0] alu, input logic [31:0] reg2,
                        input logic [31:0] rdata, input int waits,
                        input logic [3:0] ebe, input logic [31:0] ewd);
    logic memop, load, mis, tmo;
    int   w;
    exp_t e, g;
    memop = mc[MC_READ] | mc[MC_WRITE];
    load  = mc[MC_READ];
    mis   = memop && ((f3[1:0] == 2'b01 && alu[0]) || (f3[1:0] == 2'b10 && alu[1:0] != 2'b00));
    tmo   = memop && !mis && waits >= TO;
    w     = tmo ? TO : waits;
    op_n++;
    exmemFunc3 = f3; exmemMemCtrl = mc; exmemWbCtrl = wb; exmemAlu = alu;
    exmemReg2 = reg2; exmemRd = 5'(op_n); exmemZero = 1'b0;
    dmem.dmemRdata = rdata;
    e.rd = 5'(op_n); e.alu = alu; e.wb = (mis || tmo) ? 2'b00 : wb;
    sb.push_back(e);
    if (memop && !mis) begin
      for (int c = 0; c <= w; c++) begin
        dmem.dmemAck = (c == w) && !tmo;
        #1;
        chk({tag, "/req"}, dmem.dmemReq, 1);
        chk({tag, "/addr"}, dmem.dmemAddr, {alu[31:2], 2'b00});
        chk({tag, "/stall"}, memStall, c < w);
        chk({tag, "/we"}, dmem.dmemWe, !load);
        chk({tag, "/be"}, dmem.dmemBe, load ? 4'hF : ebe);
        if (!load) chk({tag, "/wdata"}, dmem.dmemWdata, ewd);
        @(posedge clk); #1;
        if (c < w) chk({tag, "/stall_bubble"}, memwbWbCtrl, 2'b00);
      end
      dmem.dmemAck = 1'b0;
      if (!tmo) begin
        rdata_known = load;
        exp_rdata   = ld_model(f3, alu[1:0], rdata);
      end
    end else begin
      dmem.dmemAck = 1'b1;  // must be ignored: no request outstanding
      #1;
      chk({tag, "/req"}, dmem.dmemReq, 0);
      chk({tag, "/stall"}, memStall, 0);
      @(posedge clk); #1;
      dmem.dmemAck = 1'b0;
    end
    g = sb.pop_front();
    chk({tag, "/memwbRd"}, memwbRd, g.rd);
    chk({tag, "/memwbWbCtrl"}, memwbWbCtrl, g.wb);
    chk({tag, "/memwbAlu"}, memwbAlu, g.alu);
    if (rdata_known) chk({tag, "/memwbReadData"}, memwbReadData, exp_rdata);
    if (mis || tmo) exp_fault = 1'b1;
    chk({tag, "/memFault"}, memFault, exp_fault);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "/req"}, dmem.dmemReq, 0);
    chk({tag, "/stall"}, memStall, 0);
    chk({tag, "/wbctrl"}, memwbWbCtrl, 0);
    chk({tag, "/rd"}, memwbRd, 0);
    chk({tag, "/alu"}, memwbAlu, 0);
    chk({tag, "/rdata"}, memwbReadData, 0);
    chk({tag, "/fault"}, memFault, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive_nop();
    #1;
    check_reset_vals(tag);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_fault = 1'b0; rdata_known = 1'b1; exp_rdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    drive_nop();
    #1;
    check_reset_vals("por");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    rdata_known = 1'b1;

    //      tag      f3      mc      wb     alu           reg2          rdata         waits ebe     ewd
    run_op("alu",   F3_LW,  3'b000, 2'b01, 32'h0000_1234, 32'h0,        32'h0,        0,    4'h0,   32'h0);
    run_op("lw0",   F3_LW,  3'b010, 2'b11, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0,   4'hF,   32'h0);
    run_op("alu_ak",F3_LW,  3'b000, 2'b01, 32'h0000_0055, 32'h0,        32'h1111_1111, 0,   4'h0,   32'h0);
    run_op("lb3",   F3_LB,  3'b010, 2'b11, 32'h0000_0103, 32'h0,        32'h8012_3456, 3,   4'hF,   32'h0);
    run_op("lbu3",  F3_LBU, 3'b010, 2'b11, 32'h0000_0103, 32'h0,        32'h8012_3456, 3,   4'hF,   32'h0);
    run_op("lh",    F3_LH,  3'b010, 2'b11, 32'h0000_0102, 32'h0,        32'h8001_1234, 1,   4'hF,   32'h0);
    run_op("lhu",   F3_LHU, 3'b010, 2'b11, 32'h0000_0100, 32'h0,        32'h1234_F00F, 2,   4'hF,   32'h0);
    run_op("rw_ld", F3_LW,  3'b011, 2'b11, 32'h0000_0200, 32'h5555_5555, 32'h0BAD_F00D, 0,  4'hF,   32'h0);
    run_op("sh",    F3_SH,  3'b001, 2'b00, 32'h0000_0022, 32'h0000_ABCD, 32'h0,       1,    4'b1100, 32'hABCD_ABCD);
    run_op("sb",    F3_SB,  3'b001, 2'b00, 32'h0000_0041, 32'h0000_005A, 32'h0,       0,    4'b0010, 32'h5A5A_5A5A);
    run_op("sw",    F3_SW,  3'b001, 2'b00, 32'h0000_0044, 32'hCAFE_F00D, 32'h0,       2,    4'b1111, 32'hCAFE_F00D);
    run_op("mis_lw",F3_LW,  3'b010, 2'b11, 32'h0000_0101, 32'h0,        32'h0,        0,    4'hF,   32'h0);
    run_op("alu2",  F3_LW,  3'b000, 2'b01, 32'h0000_0777, 32'h0,        32'h0,        0,    4'h0,   32'h0);

    do_reset("rst1");
    run_op("mis_lh",F3_LH,  3'b010, 2'b11, 32'h0000_0023, 32'h0,        32'h0,        0,    4'hF,   32'h0);
    do_reset("rst2");
    run_op("tmo",   F3_LW,  3'b010, 2'b11, 32'h0000_0300, 32'h0,        32'h0,        TO,   4'hF,   32'h0);
    run_op("post",  F3_LW,  3'b000, 2'b01, 32'h0000_0999, 32'h0,        32'h0,        0,    4'h0,   32'h0);

    // Reset in the middle of a wait.
    do_reset("rst3");
    exmemFunc3 = F3_LW; exmemMemCtrl = 3'b010; exmemWbCtrl = 2'b11;
    exmemAlu = 32'h0000_0400; exmemRd = 5'd9; dmem.dmemAck = 1'b0; dmem.dmemRdata = 32'h7777_7777;
    repeat (3) @(posedge clk);
    #1;
    chk("midwait/stall", memStall, 1);
    chk("midwait/req", dmem.dmemReq, 1);
    rst = 1'b1;
    #1;
    chk("arst/req", dmem.dmemReq, 0);
    chk("arst/stall", memStall, 0);
    chk("arst/wbctrl", memwbWbCtrl, 0);
    chk("arst/rd", memwbRd, 0);
    drive_nop();
    @(posedge clk); #1;
    rst = 1'b0;
    dmem.dmemAck = 1'b1; dmem.dmemRdata = 32'h7777_7777;
    #1;
    chk("late_ack/req", dmem.dmemReq, 0);
    chk("late_ack/stall", memStall, 0);
    @(posedge clk); #1;
    chk("late_ack/rdata", memwbReadData, 0);
    chk("late_ack/fault", memFault, 0);
    dmem.dmemAck = 1'b0;

    // Branch resolution is purely combinational.
    exmemMemCtrl = 3'b100; exmemZero = 1'b1;
    #1;
    chk("pcsrc/taken", pcSrc, 1);
    exmemZero = 1'b0;
    #1;
    chk("pcsrc/not_taken", pcSrc, 0);
    exmemMemCtrl = 3'b000; exmemZero = 1'b1;
    #1;
    chk("pcsrc/no_branch", pcSrc, 0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Stage-4 (MEM) of the riscie pipeline: consumer end of the EX/MEM register driven by the execute stage.
- Turns EX/MEM control and data into load/store transactions on a req/ack data-memory port.
- Aligns and sign-extends load data, resolves branches, and registers MEM/WB.
- Stalls the pipeline while a memory access is outstanding.

Parameters:
TIMEOUT, 16, max cycles in WAIT before the access is abandoned and memFault is set
ADDR_W, 32, data-memory address width

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
exmemAlu  in  32  effective address / ALU result
exmemReg2  in  32  store data
exmemRd  in  5  destination register
exmemZero  in  1  ALU zero flag
exmemFunc3  in  3  access size/sign; new EX/MEM field added with this block
exmemMemCtrl  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
exmemWbCtrl  in  2  [1]=MemtoReg, [0]=RegWrite
dmemReq  out  1  access request
dmemWe  out  1  1=store
dmemAddr  out  ADDR_W  word-aligned address ({exmemAlu[31:2],2'b00})
dmemWdata  out  32  lane-replicated store data
dmemBe  out  4  byte enables
dmemAck  in  1  access complete; rdata valid same cycle
dmemRdata  in  32  raw read word
memStall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
pcSrc  out  1  branch taken = Branch & exmemZero (combinational)
memwbRd  out  5  registered
memwbWbCtrl  out  2  registered; forced 2'b00 on bubble
memwbAlu  out  32  registered
memwbReadData  out  32  registered, aligned and extended load data
memFault  out  1  sticky misalign/timeout flag

Behaviour:
- memop = MemRead | MemWrite. If both are set, treat as a load.
- Misaligned access is detected combinationally:
  - halfword (func3[1:0]=01) with addr[0]=1
  - word (func3[1:0]=10) with addr[1:0]!=0
- FSM states: IDLE, WAIT.
- IDLE, no memop:
  - MEM/WB captures Rd, WbCtrl and Alu on every posedge.
  - memStall=0; dmemReq=0.
- IDLE, memop, misaligned:
  - No request is issued; memFault<=1.
  - MEM/WB captures a bubble (WbCtrl=00); memStall=0.
- IDLE, memop, aligned:
  - dmemReq=1 combinationally.
  - ack=1 in the same cycle: complete (zero-wait) and stay IDLE.
  - ack=0: memStall=1, go to WAIT, cycle counter cleared; MEM/WB captures a bubble.
- WAIT:
  - dmemReq held at 1; address, data, be and we held stable, since EX/MEM is frozen.
  - ack=1: complete, memStall=0 that cycle, go to IDLE.
  - ack=0: counter increments and memStall=1.
  - Counter reaches TIMEOUT-1 with no ack: dmemReq drops next cycle, memFault<=1, MEM/WB captures a bubble, go to IDLE, memStall=0.
- Complete means MEM/WB captures Rd, WbCtrl, Alu and the aligned load data.
  - Load data: byte/half selected by addr[1:0]/addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Stores capture as usual; WbCtrl is normally 00.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{byte}}
  - SH: be=0011<<{addr[1],1'b0}, wdata={2{half}}
  - SW: be=1111
- Loads drive be=1111 and we=0.
- Handshake: ack is ignored when dmemReq=0. At most one access is outstanding at a time.
- pcSrc is not gated by memStall. Upstream hazard logic must ignore pcSrc while memStall=1.
- Reset (async, any state, including mid-WAIT): state=IDLE, counter=0, memFault=0, dmemReq=0, memwbWbCtrl=00, memwbRd=0, memwbAlu=0, memwbReadData=0.
  - An access abandoned by reset is not retried.
- Latency: a zero-wait access puts its result in MEM/WB one posedge after the access cycle. Each wait cycle adds one.

Decomposition:
- Package riscie_pkg:
  - func3 codes (LB/LH/LW/LBU/LHU/SB/SH/SW)
  - MemCtrl/WbCtrl bit indices
  - FSM state encodings
- Sub-module mem_align: combinational store-lane and be generation plus load extract/extend, reused by a future cache.
- The FSM and MEM/WB register stay in mem_stage.

Test Plan:
- LW zero-wait: addr=0x100, rdata=0xDEADBEEF, ack same cycle -> memStall never 1; next cycle memwbReadData=0xDEADBEEF, memwbWbCtrl=11.
- LB with 3 wait states: addr=0x103, rdata=0x80xxxxxx -> memStall=1 for 3 cycles, req held, addr=0x100 stable; then memwbReadData=0xFFFFFF80. Same setup with LBU -> 0x00000080.
- SH: addr=0x22, reg2=0x0000ABCD -> be=1100, wdata=0xABCDABCD, we=1; memwbWbCtrl=00.
- Misaligned LW: addr=0x101 -> dmemReq stays 0, memFault=1 next cycle, bubble in MEM/WB, no stall.
- Timeout: TIMEOUT=4, ack held 0 -> memStall=1 for exactly 4 cycles, then dmemReq=0 and memFault=1; a following ALU op passes normally.
- Reset mid-WAIT: assert rst after 2 wait cycles -> dmemReq=0, memStall=0, memwbWbCtrl=00 immediately (async); a late ack is ignored. Also: Branch=1, Zero=1 -> pcSrc=1 in the same cycle.
